// File: rtl/cal_div_seq.sv
// ---------------------------------------------------------------------------
// cal_div_seq
// Sequential unsigned restoring divider for the calculator datapath.
// One quotient bit is resolved per clock; results are registered and held
// until the next completed operation.
//
// Ports:
//   clk          system clock, rising-edge active
//   rst_n        asynchronous active-low reset
//   start        request a division (accepted when not busy)
//   a            dividend, sampled on the accepting edge
//   b            divisor, sampled on the accepting edge
//   busy         division in flight; start is ignored while high
//   done         one-cycle completion pulse
//   quot         quotient a / b (all ones when b was 0)
//   rem          remainder a % b (captured a when b was 0)
//   div_by_zero  set at completion when the captured divisor was 0
// ---------------------------------------------------------------------------
module cal_div_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   prem_q,  prem_d;   // partial remainder, one guard bit
    logic [WIDTH-1:0] work_q,  work_d;   // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvsr_q,  dvsr_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dbz_q,   dbz_d;
    logic             done_q,  done_d;
    logic             busy_q,  busy_d;

    logic             accept_s;
    logic             dvsr_zero_s;
    logic             last_s;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH+1:0] trial_s;
    logic [WIDTH:0]   prem_next_s;
    logic [WIDTH-1:0] work_next_s;

    // A new operation is taken in IDLE and also on the single DONE cycle.
    assign accept_s    = start && (state_q != S_CALC);
    assign dvsr_zero_s = (dvsr_q == {WIDTH{1'b0}});
    assign last_s      = (cnt_q == CW'(1));

    // One restoring step: shift, trial subtract, keep or restore.
    always_comb begin
        shift_s = {prem_q[WIDTH-1:0], work_q[WIDTH-1]};
        // Extra MSB of trial_s acts as the borrow / sign of the subtraction.
        trial_s = {1'b0, shift_s} - {2'b00, dvsr_q};
        if (trial_s[WIDTH+1]) begin
            prem_next_s = shift_s;
        end else begin
            prem_next_s = trial_s[WIDTH:0];
        end
        work_next_s = {work_q[WIDTH-2:0], ~trial_s[WIDTH+1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if (dvsr_zero_s || last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_CALC;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and registered output next values.
    always_comb begin
        prem_d = prem_q;
        work_d = work_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (accept_s) begin
            work_d = a;
            dvsr_d = b;
            prem_d = {(WIDTH+1){1'b0}};
            cnt_d  = CW'(WIDTH);
            dbz_d  = 1'b0;
            busy_d = 1'b1;
        end else if (state_q == S_CALC) begin
            if (dvsr_zero_s) begin
                // No iterations: the dividend is still untouched in work_q.
                quot_d = {WIDTH{1'b1}};
                rem_d  = work_q;
                dbz_d  = 1'b1;
                done_d = 1'b1;
                busy_d = 1'b0;
            end else begin
                prem_d = prem_next_s;
                work_d = work_next_s;
                cnt_d  = cnt_q - CW'(1);
                if (last_s) begin
                    // Partial remainder is below the divisor, so it fits WIDTH bits.
                    quot_d = work_next_s;
                    rem_d  = prem_next_s[WIDTH-1:0];
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    done_d = 1'b0;
                end
            end
        end else begin
            done_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prem_q <= {(WIDTH+1){1'b0}};
            work_q <= {WIDTH{1'b0}};
            dvsr_q <= {WIDTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
            quot_q <= {WIDTH{1'b0}};
            rem_q  <= {WIDTH{1'b0}};
            dbz_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            prem_q <= prem_d;
            work_q <= work_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dbz_q  <= dbz_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_cal_div_seq.sv
// ---------------------------------------------------------------------------
// tb_cal_div_seq
// Directed and randomized bench for cal_div_seq (WIDTH=4). Expected results
// come from plain integer division / modulo in the bench.
// ---------------------------------------------------------------------------
module tb_cal_div_seq;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_by_zero;

    int vectors;
    int miscompares;

    cal_div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer division with the divide-by-zero convention.
    function automatic logic [W-1:0] ref_quot(input int x, input int y);
        if (y == 0) return 4'hF;
        return W'(x / y);
    endfunction

    function automatic logic [W-1:0] ref_rem(input int x, input int y);
        if (y == 0) return W'(x);
        return W'(x % y);
    endfunction

    // One operation; inj>0 pulses a 6/2 start at the negedge after edge k+inj-1.
    task automatic run_op(input int ta, input int tb_, input int inj, input string tag);
        int j;
        logic [W-1:0] hq;
        logic [W-1:0] hr;
        @(negedge clk);
        a = W'(ta);
        b = W'(tb_);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        chk({tag, "_busy_k"}, 32'(busy), 32'd1);
        j = 0;
        while (done !== 1'b1 && j < 20) begin
            if (j > 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
            start = (inj > 0 && j == inj - 1) ? 1'b1 : 1'b0;
            if (start) begin
                a = 4'd6;
                b = 4'd2;
            end
            @(posedge clk);
            j++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_latency"}, 32'(j), (tb_ == 0) ? 32'd1 : 32'd4);
        chk({tag, "_quot"}, 32'(quot), 32'(ref_quot(ta, tb_)));
        chk({tag, "_rem"}, 32'(rem), 32'(ref_rem(ta, tb_)));
        chk({tag, "_dbz"}, 32'(div_by_zero), (tb_ == 0) ? 32'd1 : 32'd0);
        chk({tag, "_busy_done"}, 32'(busy), 32'd0);
        hq = quot;
        hr = rem;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_done_drop"}, 32'(done), 32'd0);
            chk({tag, "_quot_hold"}, 32'(quot), 32'(hq));
            chk({tag, "_rem_hold"}, 32'(rem), 32'(hr));
        end
    endtask

    initial begin
        int ea;
        int eb;
        int j;
        int done_cnt;
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quot", 32'(quot), 32'd0);
        chk("rst_rem", 32'(rem), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed operations
        run_op(13, 4, 0, "d13_4");
        run_op(3, 7, 0, "d3_7");
        run_op(15, 1, 0, "d15_1");
        run_op(15, 15, 0, "d15_15");
        run_op(9, 0, 0, "d9_0");
        run_op(8, 2, 0, "d8_2");

        // Start pulse at edge k+2 while 13/4 is in flight is ignored
        run_op(13, 4, 2, "ign13_4");

        // Reset in the middle of a calculation
        @(negedge clk);
        a = 4'd13;
        b = 4'd4;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_quot", 32'(quot), 32'd0);
        chk("mid_rst_rem", 32'(rem), 32'd0);
        chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_rst_no_done", 32'(done), 32'd0);
            chk("post_rst_idle", 32'(busy), 32'd0);
        end
        run_op(14, 3, 0, "d14_3");

        // Randomized single operations
        for (int n = 0; n < 24; n++) begin
            run_op(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 0, "rnd");
        end

        // Exhaustive back-to-back sweep with start held high
        done_cnt = 0;
        @(negedge clk);
        a = 4'd0;
        b = 4'd0;
        start = 1'b1;
        for (int idx = 0; idx < 256; idx++) begin
            ea = idx / 16;
            eb = idx % 16;
            @(posedge clk);
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            chk("x_busy", 32'(busy), 32'd1);
            j = 0;
            while (done !== 1'b1 && j < 20) begin
                @(posedge clk);
                j++;
                @(negedge clk);
            end
            if (done === 1'b1) done_cnt++;
            chk("x_latency", 32'(j), (eb == 0) ? 32'd1 : 32'd4);
            chk("x_quot", 32'(quot), 32'(ref_quot(ea, eb)));
            chk("x_rem", 32'(rem), 32'(ref_rem(ea, eb)));
            chk("x_dbz", 32'(div_by_zero), (eb == 0) ? 32'd1 : 32'd0);
            if (idx < 255) begin
                a = W'((idx + 1) / 16);
                b = W'((idx + 1) % 16);
            end else begin
                start = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        chk("x_done_count", 32'(done_cnt), 32'd256);
        chk("x_final_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
